// File: rtl/regfile_shift_ctrl.sv
// Loads a pattern into an external shift register file, shifts it out one bit
// per cycle, and captures the serial stream into a registered output.
module regfile_shift_ctrl #(
    parameter int DATA_WIDTH = 192,
    parameter int CNT_W      = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    input  logic [DATA_WIDTH-1:0] req_data,
    output logic                  req_ready,
    input  logic                  abort,
    output logic                  rf_en,
    output logic [DATA_WIDTH-1:0] rf_data,
    input  logic                  rf_shift_out,
    output logic                  ser_bit,
    output logic                  ser_valid,
    output logic [CNT_W-1:0]      bit_cnt,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t                  state_r;
    state_t                  next_state_s;
    logic                    req_ready_s;
    logic                    accept_s;
    logic                    rf_en_r;
    logic                    busy_r;
    logic                    done_r;
    logic [DATA_WIDTH-1:0]   rf_data_r;
    logic [CNT_W-1:0]        bit_cnt_r;
    logic                    ser_bit_r;
    logic                    ser_valid_r;

    // Ready is gated by reset so nothing is offered while the block is held.
    assign req_ready_s = (state_r == IDLE) && rst_n;
    assign accept_s    = req_valid && req_ready_s;

    // Next-state decode; abort only matters while a pattern is in flight.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    next_state_s = LOAD;
                end else begin
                    next_state_s = IDLE;
                end
            end
            LOAD: begin
                if (abort) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = SHIFT;
                end
            end
            SHIFT: begin
                if (abort) begin
                    next_state_s = IDLE;
                end else if (bit_cnt_r == LAST_CNT) begin
                    next_state_s = DONE;
                end else begin
                    next_state_s = SHIFT;
                end
            end
            DONE: begin
                next_state_s = IDLE;
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // State register with state-decoded outputs registered from the next state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
            rf_en_r <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= next_state_s;
            rf_en_r <= (next_state_s == SHIFT);
            busy_r  <= (next_state_s != IDLE);
            done_r  <= (next_state_s == DONE);
        end
    end

    // Pattern capture and shift counter; the counter keeps its final value after a transfer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rf_data_r <= '0;
            bit_cnt_r <= '0;
        end else begin
            if (accept_s) begin
                rf_data_r <= req_data;
                bit_cnt_r <= '0;
            end else if (state_r == SHIFT) begin
                bit_cnt_r <= bit_cnt_r + CNT_ONE;
            end
        end
    end

    // Serial capture: sample the regfile output on every shift edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ser_bit_r   <= 1'b0;
            ser_valid_r <= 1'b0;
        end else begin
            if (state_r == SHIFT) begin
                ser_bit_r   <= rf_shift_out;
                ser_valid_r <= 1'b1;
            end else begin
                ser_valid_r <= 1'b0;
            end
        end
    end

    assign req_ready = req_ready_s;
    assign rf_en     = rf_en_r;
    assign rf_data   = rf_data_r;
    assign ser_bit   = ser_bit_r;
    assign ser_valid = ser_valid_r;
    assign bit_cnt   = bit_cnt_r;
    assign busy      = busy_r;
    assign done      = done_r;

endmodule

// File: tb/tb_regfile_shift_ctrl.sv
// Directed bench for regfile_shift_ctrl with an MSB-first regfile model.
module tb_regfile_shift_ctrl;

    localparam int DW = 192;
    localparam int CW = 8;

    localparam logic [DW-1:0] P1 = 192'h123456789123456789ABCDEF123456789123456789ABCDEF;
    localparam logic [DW-1:0] P2 = 192'hFEDCBA9876543210_0F1E2D3C4B5A6978_8796A5B4C3D2E1F0;
    localparam logic [DW-1:0] P3 = 192'h8000_0000_0000_0000_0000_0000_0000_0000_0000_0000_0000_0001;
    localparam logic [DW-1:0] P4 = 192'hDEADBEEF_CAFEF00D_0123_4567_89AB_CDEF_1357_9BDF_2468_ACE0;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid;
    logic [DW-1:0] req_data;
    logic          req_ready;
    logic          abort;
    logic          rf_en;
    logic [DW-1:0] rf_data;
    logic          rf_shift_out;
    logic          ser_bit;
    logic          ser_valid;
    logic [CW-1:0] bit_cnt;
    logic          busy;
    logic          done;

    int errors = 0;
    int checks = 0;

    // monitor state, written only by the negedge monitor
    int            cyc = 0;
    int            n_valid = 0;
    int            n_done = 0;
    int            done_cyc = 0;
    int            acc_cyc = 0;
    int            prev_acc = 0;
    logic [DW-1:0] cap = '0;

    logic [DW-1:0] rf_model;

    regfile_shift_ctrl #(.DATA_WIDTH(DW), .CNT_W(CW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .abort        (abort),
        .rf_en        (rf_en),
        .rf_data      (rf_data),
        .rf_shift_out (rf_shift_out),
        .ser_bit      (ser_bit),
        .ser_valid    (ser_valid),
        .bit_cnt      (bit_cnt),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    // Behavioural regfile: rf_en 0 loads, rf_en 1 shifts left, MSB is the serial output.
    always @(posedge clk) begin
        if (!rf_en) begin
            rf_model <= rf_data;
        end else begin
            rf_model <= {rf_model[DW-2:0], 1'b0};
        end
    end
    assign rf_shift_out = rf_model[DW-1];

    // Mid-cycle monitor: serial stream, done pulses and accept cycles.
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (ser_valid) begin
            cap     <= {cap[DW-2:0], ser_bit};
            n_valid <= n_valid + 1;
        end
        if (done) begin
            n_done   <= n_done + 1;
            done_cyc <= cyc;
        end
        if (req_valid && req_ready) begin
            prev_acc <= acc_cyc;
            acc_cyc  <= cyc;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_b(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_n(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_d(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        int v0;
        int d0;
        int en_hi;
        int en_lo;
        int bz;
        int bad;
        logic [DW-1:0] p5;
        p5 = ~P1;

        // reset
        rst_n = 1'b0; req_valid = 1'b0; req_data = '0; abort = 1'b0;
        step();
        step();
        check_b("rst_req_ready", req_ready, 1'b0);
        check_b("rst_busy", busy, 1'b0);
        check_b("rst_rf_en", rf_en, 1'b0);
        check_b("rst_done", done, 1'b0);
        check_b("rst_ser_valid", ser_valid, 1'b0);
        check_b("rst_ser_bit", ser_bit, 1'b0);
        check_n("rst_bit_cnt", int'(bit_cnt), 0);
        check_d("rst_rf_data", rf_data, '0);
        rst_n = 1'b1;
        #1;
        check_b("rel_req_ready", req_ready, 1'b1);

        // nominal transfer
        req_valid = 1'b1; req_data = P1;
        step();
        req_valid = 1'b0;
        check_b("load_rf_en", rf_en, 1'b0);
        check_b("load_busy", busy, 1'b1);
        check_b("load_req_ready", req_ready, 1'b0);
        check_d("load_rf_data", rf_data, P1);
        check_n("load_bit_cnt", int'(bit_cnt), 0);
        v0 = n_valid;
        d0 = n_done;
        step();
        en_hi = 0; en_lo = 0;
        for (int i = 0; i < 300 && !done; i++) begin
            if (rf_en) en_hi++; else en_lo++;
            step();
        end
        check_b("nom_done", done, 1'b1);
        check_n("nom_rf_en_hi", en_hi, 192);
        check_n("nom_rf_en_lo", en_lo, 0);
        check_b("nom_done_rf_en", rf_en, 1'b0);
        check_n("nom_bit_cnt", int'(bit_cnt), 192);
        check_n("nom_done_before", n_done, d0);
        step();
        check_n("nom_valid_pulses", n_valid - v0, 192);
        check_d("nom_serial_order", cap, P1);
        check_n("nom_latency", done_cyc - acc_cyc, 194);
        check_n("nom_done_once", n_done, d0 + 1);
        check_b("nom_done_clear", done, 1'b0);
        check_b("nom_idle_ready", req_ready, 1'b1);
        check_b("nom_idle_busy", busy, 1'b0);
        check_n("nom_cnt_hold", int'(bit_cnt), 192);

        // idle hold
        step();
        step();
        check_d("idle_rf_data_hold", rf_data, P1);
        check_b("idle_busy", busy, 1'b0);
        check_n("idle_cnt_hold", int'(bit_cnt), 192);

        // back-to-back with valid held high through SHIFT and DONE
        req_valid = 1'b1; req_data = P2;
        step();
        req_data = P3;
        bz = 0; en_lo = 0; bad = 0;
        for (int i = 0; i < 400 && !req_ready; i++) begin
            bz++;
            if (!rf_en) en_lo++;
            if (rf_data !== P2) bad++;
            step();
        end
        check_n("b2b_busy_cycles", bz, 194);
        check_n("b2b_rf_en_lo", en_lo, 2);
        check_n("b2b_rf_data_hold", bad, 0);
        check_d("b2b_serial", cap, P2);
        step();
        req_valid = 1'b0;
        check_n("b2b_accept_gap", acc_cyc - prev_acc, 195);
        check_d("b2b_second_data", rf_data, P3);

        // abort at bit_cnt 50
        for (int i = 0; i < 100 && int'(bit_cnt) != 50; i++) step();
        check_n("abort_reach", int'(bit_cnt), 50);
        d0 = n_done;
        abort = 1'b1;
        step();
        abort = 1'b0;
        check_b("abort_busy", busy, 1'b0);
        check_b("abort_rf_en", rf_en, 1'b0);
        check_n("abort_bit_cnt", int'(bit_cnt), 51);
        check_b("abort_req_ready", req_ready, 1'b1);
        check_b("abort_last_valid", ser_valid, 1'b1);
        step();
        check_b("abort_valid_off", ser_valid, 1'b0);
        check_n("abort_no_done", n_done, d0);
        check_n("abort_cnt_hold", int'(bit_cnt), 51);

        // abort together with a request in IDLE: request wins
        abort = 1'b1; req_valid = 1'b1; req_data = P4;
        step();
        abort = 1'b0; req_valid = 1'b0;
        check_b("idle_abort_busy", busy, 1'b1);
        check_d("idle_abort_data", rf_data, P4);
        check_n("idle_abort_cnt", int'(bit_cnt), 0);

        // reset for one edge at bit_cnt 100
        for (int i = 0; i < 200 && int'(bit_cnt) != 100; i++) step();
        check_n("mid_rst_reach", int'(bit_cnt), 100);
        d0 = n_done;
        rst_n = 1'b0;
        step();
        check_b("mid_rst_busy", busy, 1'b0);
        check_b("mid_rst_rf_en", rf_en, 1'b0);
        check_b("mid_rst_ready", req_ready, 1'b0);
        check_b("mid_rst_valid", ser_valid, 1'b0);
        check_b("mid_rst_ser_bit", ser_bit, 1'b0);
        check_n("mid_rst_cnt", int'(bit_cnt), 0);
        check_d("mid_rst_rf_data", rf_data, '0);
        rst_n = 1'b1;
        #1;
        check_b("mid_rst_rel_ready", req_ready, 1'b1);

        // full transfer after reset
        req_valid = 1'b1; req_data = p5;
        step();
        req_valid = 1'b0;
        for (int i = 0; i < 300 && !done; i++) step();
        check_b("post_rst_done", done, 1'b1);
        check_n("post_rst_cnt", int'(bit_cnt), 192);
        check_n("post_rst_no_early_done", n_done, d0);
        step();
        check_d("post_rst_serial", cap, p5);
        check_n("post_rst_done_once", n_done, d0 + 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/regfile_shift_ctrl.md
REGFILE_SHIFT_CTRL -- requirements
Module: regfile_shift_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 192: width of the pattern held by the shift register file.
REQ-002 Parameter CNT_W, default 8: bit-counter width; it SHALL satisfy 2^CNT_W > DATA_WIDTH.
REQ-003 Port clk  input  1: single clock; all state updates on the rising edge.
REQ-004 Port rst_n  input  1: synchronous, active-low reset, sampled on the rising clk edge.
REQ-005 Port req_valid  input  1: requester offers a pattern.
REQ-006 Port req_data  input  DATA_WIDTH: pattern to shift out.
REQ-007 Port req_ready  output  1: controller accepts a pattern this cycle.
REQ-008 Port abort  input  1: cancel the transfer in progress.
REQ-009 Port rf_en  output  1: regfile enable; 0 = parallel load, 1 = shift.
REQ-010 Port rf_data  output  DATA_WIDTH: regfile parallel-load data.
REQ-011 Port rf_shift_out  input  1: regfile serial output.
REQ-012 Port ser_bit  output  1: registered copy of rf_shift_out.
REQ-013 Port ser_valid  output  1: ser_bit holds a valid shifted bit.
REQ-014 Port bit_cnt  output  CNT_W: number of shift cycles issued in the current transfer.
REQ-015 Port busy  output  1: state is not IDLE.
REQ-016 Port done  output  1: one-cycle pulse marking a completed transfer.

Function
REQ-017 FSM states SHALL be exactly IDLE, LOAD, SHIFT and DONE.
REQ-018 req_ready SHALL be 1 only when state is IDLE and rst_n is 1 (combinational).
REQ-019 Handshake: a pattern SHALL be accepted at an edge where req_valid and req_ready are both 1; at that edge rf_data <= req_data, bit_cnt <= 0, and the state moves to LOAD.
REQ-020 With req_valid 0 in IDLE, the state SHALL stay IDLE and rf_data SHALL hold its value.
REQ-021 LOAD SHALL last exactly one cycle with rf_en 0, then move to SHIFT.
REQ-022 In SHIFT, rf_en SHALL be 1 and bit_cnt SHALL increment by 1 on every edge.
REQ-023 SHIFT SHALL move to DONE at the edge where bit_cnt increments from DATA_WIDTH-1 to DATA_WIDTH, giving exactly DATA_WIDTH SHIFT cycles.
REQ-024 DONE SHALL last one cycle with done 1 and rf_en 0, then return to IDLE; bit_cnt SHALL hold DATA_WIDTH until the next accept.
REQ-025 rf_en SHALL be 0 in IDLE, LOAD and DONE.
REQ-026 rf_en SHALL never drop to 0 mid-SHIFT except on abort; there is no stall, because rf_en 0 reloads the regfile.
REQ-027 At every edge where the state is SHIFT, ser_bit <= rf_shift_out and ser_valid <= 1.
REQ-028 At all other edges, ser_valid <= 0 and ser_bit holds its value; ser_valid therefore pulses exactly DATA_WIDTH times per completed transfer.
REQ-029 Latency: accept at cycle t gives LOAD at t+1, SHIFT at t+2..t+DATA_WIDTH+1, DONE (done=1) at t+DATA_WIDTH+2, and req_ready=1 again at t+DATA_WIDTH+3.
REQ-030 abort in LOAD or SHIFT SHALL force IDLE at the next edge with no done pulse; bit_cnt keeps the value reached and ser_valid is 0 from the following cycle.
REQ-031 abort in IDLE or DONE SHALL be ignored.
REQ-032 If abort and req_valid are both 1 in IDLE, the request SHALL be accepted.
REQ-033 req_valid in DONE SHALL not be accepted, because req_ready is 0.
REQ-034 busy SHALL equal (state != IDLE).

Reset
REQ-035 At an edge with rst_n 0, the following SHALL be set: state IDLE, rf_data 0, bit_cnt 0, ser_bit 0, ser_valid 0, done 0.
REQ-036 Because these outputs depend only on state, rf_en and busy SHALL also be 0 after that reset edge.
REQ-037 req_ready SHALL be 0 while rst_n is 0.
REQ-038 Reset asserted mid-SHIFT SHALL abandon the transfer with no done pulse, and IDLE SHALL follow the first edge with rst_n 1.
REQ-039 After release, req_ready SHALL be 1 in the first cycle with rst_n 1.

Verification
REQ-040 Nominal: reset, then offer 192'h123456789123456789ABCDEF123456789123456789ABCDEF -> rf_en 0 for one cycle, then rf_en 1 for 192 cycles; 192 ser_valid pulses; done at accept+194; bit_cnt=192.
REQ-041 Serial order: behavioural regfile model (MSB first) -> captured ser_bit stream equals the pattern MSB to LSB.
REQ-042 Back-to-back: req_valid held high with two patterns -> second accept exactly 195 cycles after the first; no extra rf_en 0 cycles inside SHIFT.
REQ-043 Abort at bit_cnt=50 -> IDLE next edge, done never pulses, bit_cnt=51, req_ready=1 the following cycle.
REQ-044 rst_n 0 for one edge at bit_cnt=100 -> all outputs at reset values; new request accepted and fully shifted afterwards.
REQ-045 Handshake hold: req_valid 1 during SHIFT and DONE -> no accept and rf_data unchanged until IDLE.
